// File: rtl/uart_pkg.sv
// Shared UART TX definitions.
// State encodings, parity types and line levels.
package uart_pkg;

  localparam logic [2:0] IDLE_ENC   = 3'd0;
  localparam logic [2:0] START_ENC  = 3'd1;
  localparam logic [2:0] DATA_ENC   = 3'd2;
  localparam logic [2:0] PARITY_ENC = 3'd3;
  localparam logic [2:0] STOP1_ENC  = 3'd4;
  localparam logic [2:0] STOP2_ENC  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE_ENC,
    ST_START  = START_ENC,
    ST_DATA   = DATA_ENC,
    ST_PARITY = PARITY_ENC,
    ST_STOP1  = STOP1_ENC,
    ST_STOP2  = STOP2_ENC
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  function automatic logic par_bit(
    input logic red,
    input logic typ
  );
    return (typ == PAR_EVEN) ? red : ~red;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Payload shift register and bit counter.
// Shifts LSB first; last_bit flags the final payload bit.
module uart_tx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  bit_out,
  output logic                  last_bit
);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;

  // Counter preloads to all-ones so the shift that
  // launches bit 0 onto the line lands it on zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '1;
    end else if (shift) begin
      sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign bit_out  = sreg[0];
  assign last_bit = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame engine.
// Start, payload, optional parity, 1 or 2 stop bits.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t state;
  logic   par_en_q;
  logic   par_q;
  logic   stop2_q;
  logic   bit_out;
  logic   last_bit;
  logic   final_stop;
  logic   accept;
  logic   shift;

  assign final_stop = (state == ST_STOP2) ||
                      (state == ST_STOP1 && !stop2_q);
  assign accept     = Data_Valid &&
                      (state == ST_IDLE || final_stop);
  assign shift      = (state == ST_START) ||
                      (state == ST_DATA && !last_bit);

  uart_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_shifter (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift    (shift),
    .data     (P_DATA),
    .bit_out  (bit_out),
    .last_bit (last_bit)
  );

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      TX_OUT     <= IDLE_LVL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        par_en_q <= PAR_EN;
        par_q    <= par_bit(^P_DATA, PAR_TYP);
        stop2_q  <= STOP2;
      end
      case (state)
        ST_IDLE, ST_STOP2: begin
          state  <= accept ? ST_START : ST_IDLE;
          TX_OUT <= accept ? START_BIT : IDLE_LVL;
          busy   <= accept;
        end
        ST_START: begin
          state  <= ST_DATA;
          TX_OUT <= bit_out;
          busy   <= 1'b1;
        end
        ST_DATA: begin
          busy <= 1'b1;
          if (!last_bit) begin
            TX_OUT <= bit_out;
          end else if (par_en_q) begin
            state  <= ST_PARITY;
            TX_OUT <= par_q;
          end else begin
            state      <= ST_STOP1;
            TX_OUT     <= STOP_BIT;
            frame_done <= !stop2_q;
          end
        end
        ST_PARITY: begin
          state      <= ST_STOP1;
          TX_OUT     <= STOP_BIT;
          busy       <= 1'b1;
          frame_done <= !stop2_q;
        end
        ST_STOP1: begin
          if (stop2_q) begin
            state      <= ST_STOP2;
            TX_OUT     <= STOP_BIT;
            busy       <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            state  <= accept ? ST_START : ST_IDLE;
            TX_OUT <= accept ? START_BIT : IDLE_LVL;
            busy   <= accept;
          end
        end
        default: begin
          state  <= ST_IDLE;
          TX_OUT <= IDLE_LVL;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl.
// Vector table plus hand-written corner sequences.
module tb_uart_tx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  logic [4:0] d5_data;
  logic       d5_dv;
  logic       d5_pe;
  logic       d5_pt;
  logic       d5_s2;
  logic       d5_tx;
  logic       d5_busy;
  logic       d5_fd;

  int n_total;
  int n_pass;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    int          len;
    logic [0:11] bits;
    string       tag;
  } vec_t;

  vec_t vecs [6];

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(5)) dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (d5_data),
    .Data_Valid (d5_dv),
    .PAR_EN     (d5_pe),
    .PAR_TYP    (d5_pt),
    .STOP2      (d5_s2),
    .TX_OUT     (d5_tx),
    .busy       (d5_busy),
    .frame_done (d5_fd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " tx"},   {31'd0, TX_OUT},     32'd1);
    chk({name, " busy"}, {31'd0, busy},       32'd0);
    chk({name, " done"}, {31'd0, frame_done}, 32'd0);
  endtask

  // Drive a request; returns with cycle 0 on the line.
  task automatic launch(input vec_t v);
    @(negedge CLK);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    STOP2      = v.s2;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic check_frame(
    input vec_t v,
    input bit   mess,
    input bit   b2b
  );
    for (int i = 0; i < v.len; i++) begin
      if (i > 0) begin
        @(posedge CLK);
        #1;
      end
      chk($sformatf("%s tx[%0d]", v.tag, i),
          {31'd0, TX_OUT}, {31'd0, v.bits[i]});
      chk($sformatf("%s busy[%0d]", v.tag, i),
          {31'd0, busy}, 32'd1);
      chk($sformatf("%s done[%0d]", v.tag, i),
          {31'd0, frame_done},
          (i == v.len - 1) ? 32'd1 : 32'd0);
      if (mess && i == 3) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = ~PAR_EN;
        PAR_TYP    = ~PAR_TYP;
        STOP2      = ~STOP2;
      end
      if (mess && i == 4)
        Data_Valid = 1'b0;
      if (b2b && i == v.len - 2) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
      end
    end
    if (!b2b) begin
      @(posedge CLK);
      #1;
      chk_idle({v.tag, " after"});
    end
  endtask

  initial begin
    vec_t        v2;
    logic [0:11] exp5;
    n_total    = 0;
    n_pass     = 0;
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    d5_data    = '0;
    d5_dv      = 1'b0;
    d5_pe      = 1'b0;
    d5_pt      = 1'b0;
    d5_s2      = 1'b0;

    // Line order: element 0 is the first bit sent.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11,
                12'b0101_0010_1011, "A5_even"};
    vecs[1] = '{8'h0F, 1'b0, 1'b0, 1'b1, 11,
                12'b0111_1000_0111, "0F_2stop"};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11,
                12'b0111_0000_0011, "07_odd"};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b0, 11,
                12'b0110_0000_0111, "03_odd"};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 10,
                12'b0001_1110_0111, "3C_nopar"};
    vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b1, 12,
                12'b0101_0101_0011, "55_even2"};

    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset");
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_idle("post_reset");

    for (int k = 0; k < 6; k++) begin
      launch(vecs[k]);
      check_frame(vecs[k], 1'b0, 1'b0);
    end

    // Mid-frame request and config toggles ignored.
    launch(vecs[0]);
    check_frame(vecs[0], 1'b1, 1'b0);

    // Back-to-back: 0x55, no parity, one stop.
    launch(vecs[0]);
    check_frame(vecs[0], 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    v2 = '{8'h55, 1'b0, 1'b0, 1'b0, 10,
           12'b0101_0101_0111, "b2b_55"};
    check_frame(v2, 1'b0, 1'b0);

    // Reset during DATA bit 3 (cycle 4 of the frame).
    launch(vecs[0]);
    repeat (4) @(posedge CLK);
    #1;
    chk("pre_rst tx",   {31'd0, TX_OUT}, 32'd0);
    chk("pre_rst busy", {31'd0, busy},   32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk_idle("rst_hold_idle");
    end
    launch(vecs[1]);
    check_frame(vecs[1], 1'b0, 1'b0);

    // Five-bit payload, odd parity.
    exp5 = 12'b0101_0101_1111;
    @(negedge CLK);
    d5_data = 5'h15;
    d5_pe   = 1'b1;
    d5_pt   = 1'b1;
    d5_s2   = 1'b0;
    d5_dv   = 1'b1;
    @(posedge CLK);
    #1;
    d5_dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge CLK);
        #1;
      end
      chk($sformatf("w5 tx[%0d]", i),
          {31'd0, d5_tx}, {31'd0, exp5[i]});
      chk($sformatf("w5 busy[%0d]", i),
          {31'd0, d5_busy}, 32'd1);
      chk($sformatf("w5 done[%0d]", i),
          {31'd0, d5_fd}, (i == 7) ? 32'd1 : 32'd0);
    end
    @(posedge CLK);
    #1;
    chk("w5 after tx",   {31'd0, d5_tx},   32'd1);
    chk("w5 after busy", {31'd0, d5_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
